hbridge_coil_array: RTL

Parametrised N-channel H-bridge coil plant model for microstepper benches and hardware-in-loop builds. Decodes the four gate signals of each bridge into a drive state, integrates a first-order coil current with distinct drive, slow-decay and fast-decay time constants, and generates the registered comparator feedback for the stepper's `analog_cmp` inputs. Also flags shoot-through and dead-time violations per channel. It sits between `microstepper_top` gate outputs and its comparator inputs, replacing per-coil models plus bench-side comparator logic.

---
 rtl/coil_model_pkg.sv | 12 +
 rtl/hbridge_coil_channel.sv | 84 ++++++++
 rtl/hbridge_coil_array.sv | 56 +++++
 3 files changed

// File: rtl/coil_model_pkg.sv
// coil_model_pkg: drive-state encoding and integrator helpers shared by the coil plant model
package coil_model_pkg;
  typedef enum logic [2:0] {DS_SHOOT, DS_POS, DS_NEG, DS_SLOW, DS_FAST} drive_t;
  localparam int MIN_STEP = 1;
  function automatic int sat(input int v, input int m);
    return v > m ? m : v < -m ? -m : v;
  endfunction
  // A zero decay step on a nonzero current is bumped to one LSB so decay always reaches zero
  function automatic int decay_step(input int i, input int d);
    return (d == 0 && i != 0) ? (i > 0 ? MIN_STEP : -MIN_STEP) : d;
  endfunction
endpackage

// File: rtl/hbridge_coil_channel.sv
// hbridge_coil_channel: one H-bridge with gate decoder, current integrator, comparator and dead-time check
module hbridge_coil_channel
  import coil_model_pkg::*;
#(
  parameter int CUR_W      = 13,
  parameter int IMAX       = 4095,
  parameter int RISE_SHIFT = 4,
  parameter int SLOW_SHIFT = 6,
  parameter int FAST_SHIFT = 3,
  parameter int DEADTIME   = 4,
  parameter int HYST       = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    clear_faults,
  input  logic                    low_1,
  input  logic                    high_1,
  input  logic                    low_2,
  input  logic                    high_2,
  input  logic                    polarity_invert,
  input  logic [11:0]             target,
  output logic signed [CUR_W-1:0] current,
  output logic                    cmp,
  output logic                    shoot_through,
  output logic                    deadtime_err
);
  localparam int W  = CUR_W + 2;
  localparam int DW = DEADTIME > 0 ? $clog2(DEADTIME + 1) : 1;
  drive_t ds;
  logic signed [W-1:0] i_q, i_nxt, rise_p, rise_n, dec_s, dec_f, step;
  logic [W-1:0] mag, lo;
  logic [1:0] hs, ls, hs_q, ls_q, fell_hi, viol;
  logic [DW-1:0] cnt [2];
  always_comb begin
    hs = {high_2, high_1};
    ls = {low_2, low_1};
    ds = ((high_1 & low_1) | (high_2 & low_2)) ? DS_SHOOT :
         (high_1 & low_2) ? DS_POS :
         (high_2 & low_1) ? DS_NEG :
         ((low_1 & low_2) | (high_1 & high_2)) ? DS_SLOW : DS_FAST;
    rise_p = (W'(IMAX) - i_q) >>> RISE_SHIFT;
    rise_n = (-W'(IMAX) - i_q) >>> RISE_SHIFT;
    dec_s = -W'(decay_step(int'(i_q), int'(i_q >>> SLOW_SHIFT)));
    dec_f = -W'(decay_step(int'(i_q), int'(i_q >>> FAST_SHIFT)));
    step = ds == DS_POS ? rise_p : ds == DS_NEG ? rise_n :
           ds == DS_SLOW ? dec_s : ds == DS_FAST ? dec_f : W'(0);
    i_nxt = tick ? W'(sat(int'(i_q + step), IMAX)) : i_q;
    mag = i_q[W-1] ? -i_q : i_q;
    lo = W'(target) > W'(HYST) ? W'(target) - W'(HYST) : '0;
    viol = '0;
    // A violation is the opposite switch of the one that fell turning on inside the dead-time window
    for (int l = 0; l < 2; l++)
      viol[l] = cnt[l] != '0 && (fell_hi[l] ? (ls[l] & ~ls_q[l]) : (hs[l] & ~hs_q[l]));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q <= '0;
      current <= '0;
      cmp <= 1'b0;
      shoot_through <= 1'b0;
      deadtime_err <= 1'b0;
      hs_q <= '0;
      ls_q <= '0;
      fell_hi <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      i_q <= i_nxt;
      current <= CUR_W'(polarity_invert ? -i_nxt : i_nxt);
      cmp <= mag >= W'(target) ? 1'b1 : mag < lo ? 1'b0 : cmp;
      shoot_through <= ds == DS_SHOOT || (shoot_through && !clear_faults);
      deadtime_err <= |viol || (deadtime_err && !clear_faults);
      hs_q <= hs;
      ls_q <= ls;
      for (int l = 0; l < 2; l++)
        if ((hs_q[l] & ~hs[l]) | (ls_q[l] & ~ls[l])) begin
          cnt[l] <= DW'(DEADTIME);
          fell_hi[l] <= hs_q[l] & ~hs[l];
        end else if (cnt[l] != '0)
          cnt[l] <= cnt[l] - 1'b1;
    end
  end
endmodule

// File: rtl/hbridge_coil_array.sv
// hbridge_coil_array: N-channel H-bridge coil plant with shared integration tick and sticky fault flags
module hbridge_coil_array #(
  parameter int NCH        = 2,
  parameter int CUR_W      = 13,
  parameter int IMAX       = 4095,
  parameter int RISE_SHIFT = 4,
  parameter int SLOW_SHIFT = 6,
  parameter int FAST_SHIFT = 3,
  parameter int TICK_DIV   = 1,
  parameter int DEADTIME   = 4,
  parameter int HYST       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       low_1,
  input  logic [NCH-1:0]       high_1,
  input  logic [NCH-1:0]       low_2,
  input  logic [NCH-1:0]       high_2,
  input  logic [NCH-1:0]       polarity_invert,
  input  logic [NCH*12-1:0]    target,
  input  logic                 clear_faults,
  output logic [NCH*CUR_W-1:0] current,
  output logic [NCH-1:0]       cmp,
  output logic [NCH-1:0]       shoot_through,
  output logic [NCH-1:0]       deadtime_err
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre;
  logic tick;
  always_comb tick = pre == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
  end
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    hbridge_coil_channel #(
      .CUR_W(CUR_W), .IMAX(IMAX), .RISE_SHIFT(RISE_SHIFT), .SLOW_SHIFT(SLOW_SHIFT),
      .FAST_SHIFT(FAST_SHIFT), .DEADTIME(DEADTIME), .HYST(HYST)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .tick(tick),
      .clear_faults(clear_faults),
      .low_1(low_1[g]),
      .high_1(high_1[g]),
      .low_2(low_2[g]),
      .high_2(high_2[g]),
      .polarity_invert(polarity_invert[g]),
      .target(target[g*12 +: 12]),
      .current(current[g*CUR_W +: CUR_W]),
      .cmp(cmp[g]),
      .shoot_through(shoot_through[g]),
      .deadtime_err(deadtime_err[g])
    );
  end
endmodule
